// File: rtl/dff_bank_write_arbiter.sv
// Round-robin write arbiter for one shared enable-gated flip-flop bank.
// One requester wins per transaction; its data is written in a single enable cycle, then acknowledged.
module dff_bank_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   data,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         ack,
    output logic [WIDTH-1:0]           ff_d,
    output logic                       ff_enable,
    output logic                       busy,
    output logic [1:0]                 state_dbg
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Handshake: a requester raises req and holds it (data may change freely) until it
    // sees its one-cycle ack; grant stays with it until req is sampled low again.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        DONE    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t               state_q;
    logic [PW-1:0]        ptr_q;
    logic [PW-1:0]        winner_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic [NUM_REQ-1:0]   ack_q;
    logic [WIDTH-1:0]     ff_d_q;
    logic                 ff_enable_q;

    logic                 found;
    logic [PW-1:0]        win_idx;
    logic [PW-1:0]        ptr_d;
    logic [NUM_REQ-1:0]   win_onehot;
    logic [WIDTH-1:0]     win_data;

    // First requesting index at or after ptr, wrapping around.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[(int'(ptr_q) + k) % NUM_REQ]) begin
                found   = 1'b1;
                win_idx = PW'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
        ptr_d      = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);
        win_onehot = NUM_REQ'(1) << win_idx;
        win_data   = data[int'(win_idx) * WIDTH +: WIDTH];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            winner_q    <= '0;
            grant_q     <= '0;
            ack_q       <= '0;
            ff_d_q      <= '0;
            ff_enable_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        winner_q    <= win_idx;
                        grant_q     <= win_onehot;
                        ff_d_q      <= win_data;
                        ff_enable_q <= 1'b1;
                        ptr_q       <= ptr_d;
                        state_q     <= WRITE;
                    end else begin
                        grant_q     <= '0;
                        ack_q       <= '0;
                        ff_enable_q <= 1'b0;
                    end
                end
                WRITE: begin
                    ff_enable_q <= 1'b0;
                    ack_q       <= grant_q;
                    state_q     <= DONE;
                end
                DONE: begin
                    ack_q   <= '0;
                    state_q <= RELEASE;
                end
                RELEASE: begin
                    // A requester that keeps req high blocks everyone else here.
                    if (!req[winner_q]) begin
                        grant_q <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant     = grant_q;
    assign ack       = ack_q;
    assign ff_d      = ff_d_q;
    assign ff_enable = ff_enable_q;
    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_dff_bank_write_arbiter.sv
// Bench for dff_bank_write_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-timeline reference model.
module tb_dff_bank_write_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic [N-1:0]     req = '0;
    logic [N*W-1:0]   data = '0;
    logic [N-1:0]     grant;
    logic [N-1:0]     ack;
    logic [W-1:0]     ff_d;
    logic             ff_enable;
    logic             busy;
    logic [1:0]       state_dbg;

    int checks = 0;
    int errors = 0;

    // Reference model: one open transaction described by its winner, age and latched data.
    bit               m_active;
    int               m_age;
    int               m_w;
    int               m_ptr;
    logic [W-1:0]     m_d;
    int               txn;

    always #5 clock = ~clock;

    dff_bank_write_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (req),
        .data      (data),
        .grant     (grant),
        .ack       (ack),
        .ff_d      (ff_d),
        .ff_enable (ff_enable),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    function automatic int rr_pick(logic [N-1:0] r, int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic apply_reset();
        reset_n = 1'b0;
        req = '0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            req = N'($urandom);
            data = $urandom;
            @(negedge clock);
            checks++;
            if (grant !== '0 || ack !== '0 || ff_enable !== 1'b0 || ff_d !== '0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: grant=%b ack=%b en=%b ff_d=%h busy=%b, required all zero",
                         grant, ack, ff_enable, ff_d, busy);
            end
        end
        req = '0;
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_single_write();
        apply_reset();
        data = $urandom;
        data[2*W +: W] = 8'hA5;
        req = 4'b0100;
        @(negedge clock);
        checks++;
        if (grant !== 4'b0100 || ff_enable !== 1'b1 || ff_d !== 8'hA5 || ack !== '0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: grant=%b en=%b ff_d=%h ack=%b busy=%b, required 0100 1 a5 0000 1",
                     grant, ff_enable, ff_d, ack, busy);
        end
        @(negedge clock);
        checks++;
        if (ack !== 4'b0100 || ff_enable !== 1'b0 || grant !== 4'b0100) begin
            errors++;
            $display("FAIL single_ack: ack=%b en=%b grant=%b, required 0100 0 0100", ack, ff_enable, grant);
        end
        req = '0;
        @(negedge clock);
        checks++;
        if (ack !== '0 || grant !== 4'b0100 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_ack_pulse: ack=%b grant=%b busy=%b, required 0000 0100 1", ack, grant, busy);
        end
        @(negedge clock);
        checks++;
        if (grant !== '0 || busy !== 1'b0 || ff_enable !== 1'b0 || ff_d !== 8'hA5) begin
            errors++;
            $display("FAIL single_release: grant=%b busy=%b en=%b ff_d=%h, required 0000 0 0 a5",
                     grant, busy, ff_enable, ff_d);
        end
    endtask

    task automatic test_fairness();
        int seen;
        logic [W-1:0] ed;
        logic [N-1:0] eg;
        apply_reset();
        for (int i = 0; i < N; i++) data[i*W +: W] = W'(16 + i);
        req = '1;
        seen = 0;
        for (int c = 0; c < 60 && seen < 5; c++) begin
            @(negedge clock);
            if (ff_enable) begin
                ed = W'(16 + (seen % N));
                eg = N'(1) << (seen % N);
                checks++;
                if (grant !== eg || ff_d !== ed) begin
                    errors++;
                    $display("FAIL fairness_order%0d: grant=%b ff_d=%h, required %b %h", seen, grant, ff_d, eg, ed);
                end
                seen++;
            end
            for (int i = 0; i < N; i++) begin
                if (ack[i]) req[i] = 1'b0;
                else if (!req[i] && !grant[i]) req[i] = 1'b1;
            end
        end
        checks++;
        if (seen != 5) begin
            errors++;
            $display("FAIL fairness_count: enable pulses=%0d, required 5", seen);
        end
        req = '0;
    endtask

    task automatic test_stuck();
        bit got;
        apply_reset();
        data = $urandom;
        req = 4'b1010;
        @(negedge clock);
        checks++;
        if (grant !== 4'b0010 || ff_enable !== 1'b1) begin
            errors++;
            $display("FAIL stuck_first_grant: grant=%b en=%b, required 0010 1", grant, ff_enable);
        end
        @(negedge clock);
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            checks++;
            if (grant !== 4'b0010 || busy !== 1'b1 || ff_enable !== 1'b0 || ack !== '0) begin
                errors++;
                $display("FAIL stuck_hold%0d: grant=%b busy=%b en=%b ack=%b, required 0010 1 0 0000",
                         c, grant, busy, ff_enable, ack);
            end
        end
        req[1] = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 6 && !got; c++) begin
            @(negedge clock);
            if (ff_enable) begin
                got = 1'b1;
                checks++;
                if (grant !== 4'b1000 || ff_d !== data[3*W +: W]) begin
                    errors++;
                    $display("FAIL stuck_next_grant: grant=%b ff_d=%h, required 1000 %h", grant, ff_d, data[3*W +: W]);
                end
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL stuck_timeout: enable=%b, required a write within 6 cycles", ff_enable);
        end
        req = '0;
    endtask

    task automatic test_mid_reset();
        apply_reset();
        data = $urandom;
        req = 4'b0010;
        @(negedge clock);
        checks++;
        if (ff_enable !== 1'b1 || grant !== 4'b0010) begin
            errors++;
            $display("FAIL midreset_setup: en=%b grant=%b, required 1 0010", ff_enable, grant);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (ff_enable !== 1'b0 || grant !== '0 || busy !== 1'b0 || ff_d !== '0) begin
            errors++;
            $display("FAIL midreset_async: en=%b grant=%b busy=%b ff_d=%h, required 0 0000 0 00",
                     ff_enable, grant, busy, ff_d);
        end
        req = 4'b1001;
        @(negedge clock);
        checks++;
        if (ack !== '0 || grant !== '0) begin
            errors++;
            $display("FAIL midreset_no_ack: ack=%b grant=%b, required 0000 0000", ack, grant);
        end
        reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if (grant !== 4'b0001 || ff_enable !== 1'b1 || ff_d !== data[W-1:0]) begin
            errors++;
            $display("FAIL midreset_ptr: grant=%b en=%b ff_d=%h, required 0001 1 %h", grant, ff_enable, ff_d, data[W-1:0]);
        end
        req = '0;
    endtask

    task automatic test_data_stability();
        apply_reset();
        data = '0;
        data[W-1:0] = 8'h3C;
        req = 4'b0001;
        @(negedge clock);
        checks++;
        if (ff_d !== 8'h3C || grant !== 4'b0001) begin
            errors++;
            $display("FAIL stable_latch: ff_d=%h grant=%b, required 3c 0001", ff_d, grant);
        end
        data[W-1:0] = 8'hFF;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (c == 0) req = '0;
            checks++;
            if (ff_d !== 8'h3C) begin
                errors++;
                $display("FAIL stable_hold%0d: ff_d=%h, required 3c", c, ff_d);
            end
        end
        data[W +: W] = 8'h5A;
        req = 4'b0010;
        @(negedge clock);
        checks++;
        if (ff_d !== 8'h5A || grant !== 4'b0010 || ff_enable !== 1'b1) begin
            errors++;
            $display("FAIL stable_next: ff_d=%h grant=%b en=%b, required 5a 0010 1", ff_d, grant, ff_enable);
        end
        req = '0;
    endtask

    task automatic test_random();
        logic [N-1:0] eg;
        logic [N-1:0] ea;
        logic         een;
        int           en_seen;
        apply_reset();
        m_active = 1'b0;
        m_age = 0;
        m_w = 0;
        m_ptr = 0;
        m_d = '0;
        txn = 0;
        en_seen = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if (grant[i] && $urandom_range(0, 1) == 1) req[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                end
            end
            data = $urandom;
            // Advance the model to the edge that will sample these inputs.
            if (m_active) begin
                m_age++;
                if (m_age >= 3 && !req[m_w]) m_active = 1'b0;
            end else if (req != '0) begin
                m_w = rr_pick(req, m_ptr);
                m_active = 1'b1;
                m_age = 0;
                m_d = data[m_w*W +: W];
                m_ptr = (m_w + 1) % N;
                txn++;
            end
            @(negedge clock);
            eg  = m_active ? (N'(1) << m_w) : '0;
            een = m_active && (m_age == 0);
            ea  = (m_active && m_age == 1) ? eg : '0;
            if (ff_enable) en_seen++;
            checks++;
            if (grant !== eg || ack !== ea || ff_enable !== een || ff_d !== m_d || busy !== m_active) begin
                errors++;
                $display("FAIL random_cycle%0d: grant=%b ack=%b en=%b ff_d=%h busy=%b, required %b %b %b %h %b",
                         c, grant, ack, ff_enable, ff_d, busy, eg, ea, een, m_d, m_active);
            end
            checks++;
            if (!$onehot0(grant) || (ack & ~grant) !== '0) begin
                errors++;
                $display("FAIL random_invariant%0d: grant=%b ack=%b, required onehot0 grant and ack within grant",
                         c, grant, ack);
            end
        end
        checks++;
        if (en_seen != txn) begin
            errors++;
            $display("FAIL random_txn_count: enable pulses=%0d, required %0d", en_seen, txn);
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_fairness();
        test_stuck();
        test_mid_reset();
        test_data_stability();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
